// File: rtl/lv1a_pkg.sv
// Shared types and default widths for the Level-1 accept prescale/merge block.
package lv1a_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DEAD = 1'b1
    } lv1a_state_e;

    localparam int DEF_N_TYPE = 4;
    localparam int DEF_PS_W   = 16;
    localparam int DEF_DT_W   = 8;
    localparam int DEF_CNT_W  = 16;

    // LSB position of field idx in a vector of packed fields of the given width
    function automatic int field_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/lv1a_prescaler.sv
// Single-type prescaler: passes every prescale-th accepted pulse as a one-cycle hit.
module lv1a_prescaler
    import lv1a_pkg::*;
#(
    parameter int PS_W = DEF_PS_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            in_pulse,
    input  logic            in_live,
    input  logic [PS_W-1:0] prescale,
    output logic            hit
);

    localparam logic [PS_W-1:0] PS_ONE = PS_W'(1);

    logic [PS_W-1:0] cnt_q;
    logic [PS_W-1:0] cnt_d;
    logic [PS_W-1:0] cnt_base;

    // A clear and a pulse in the same cycle count the pulse from zero
    always_comb begin
        cnt_base = clr ? '0 : cnt_q;
        cnt_d    = cnt_base;
        hit      = 1'b0;
        if (prescale == '0) begin
            cnt_d = '0;
        end else if (in_pulse && in_live) begin
            if (cnt_base == prescale - PS_ONE) begin
                hit   = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_base + PS_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lv1a_prescale_merge.sv
// Merges prescaled per-type Level-1 accepts into one trigger with deadtime,
// event numbering and accepted/lost bookkeeping.
module lv1a_prescale_merge
    import lv1a_pkg::*;
#(
    parameter int N_TYPE = DEF_N_TYPE,
    parameter int PS_W   = DEF_PS_W,
    parameter int DT_W   = DEF_DT_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_TYPE-1:0]       in_lv1a,
    input  logic                    in_live,
    input  logic [N_TYPE*PS_W-1:0]  user_prescale,
    input  logic [DT_W-1:0]         user_deadtime,
    output logic                    out_lv1a,
    output logic [N_TYPE-1:0]       out_trig_bits,
    output logic [CNT_W-1:0]        out_event_num,
    output logic                    out_busy,
    output logic [N_TYPE*CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0]        lost_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [DT_W-1:0]  DT_ONE  = DT_W'(1);

    lv1a_state_e              state_q, state_d;
    logic [DT_W-1:0]          dt_cnt_q, dt_cnt_d;
    logic                     pre_live_q;
    logic                     lv1a_q, lv1a_d;
    logic [N_TYPE-1:0]        trig_bits_q, trig_bits_d;
    logic [CNT_W-1:0]         event_num_q, event_num_d;
    logic [N_TYPE*CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]         lost_cnt_q, lost_cnt_d;
    logic [N_TYPE-1:0]        hit;
    logic                     live_rise;

    assign live_rise = in_live && !pre_live_q;

    for (genvar i = 0; i < N_TYPE; i++) begin : g_ps
        lv1a_prescaler #(
            .PS_W(PS_W)
        ) u_ps (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (live_rise),
            .in_pulse (in_lv1a[i]),
            .in_live  (in_live),
            .prescale (user_prescale[field_lsb(i, PS_W) +: PS_W]),
            .hit      (hit[i])
        );
    end

    // Counters are cleared only on live rise so they stay readable during live-off
    always_comb begin
        state_d     = state_q;
        dt_cnt_d    = dt_cnt_q;
        lv1a_d      = 1'b0;
        trig_bits_d = trig_bits_q;
        event_num_d = live_rise ? '0 : event_num_q;
        acc_cnt_d   = live_rise ? '0 : acc_cnt_q;
        lost_cnt_d  = live_rise ? '0 : lost_cnt_q;

        case (state_q)
            IDLE: begin
                if ((|hit) && in_live) begin
                    lv1a_d      = 1'b1;
                    trig_bits_d = hit;
                    event_num_d = event_num_d + CNT_ONE;
                    for (int i = 0; i < N_TYPE; i++) begin
                        if (hit[i]) begin
                            acc_cnt_d[field_lsb(i, CNT_W) +: CNT_W] =
                                acc_cnt_d[field_lsb(i, CNT_W) +: CNT_W] + CNT_ONE;
                        end
                    end
                    if (user_deadtime != '0) begin
                        state_d  = DEAD;
                        dt_cnt_d = user_deadtime;
                    end
                end
            end
            DEAD: begin
                if (|hit) begin
                    lost_cnt_d = lost_cnt_d + CNT_ONE;
                end
                if (dt_cnt_q <= DT_ONE) begin
                    state_d = IDLE;
                end else begin
                    dt_cnt_d = dt_cnt_q - DT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dt_cnt_q    <= '0;
            pre_live_q  <= 1'b0;
            lv1a_q      <= 1'b0;
            trig_bits_q <= '0;
            event_num_q <= '0;
            acc_cnt_q   <= '0;
            lost_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            dt_cnt_q    <= dt_cnt_d;
            pre_live_q  <= in_live;
            lv1a_q      <= lv1a_d;
            trig_bits_q <= trig_bits_d;
            event_num_q <= event_num_d;
            acc_cnt_q   <= acc_cnt_d;
            lost_cnt_q  <= lost_cnt_d;
        end
    end

    assign out_lv1a      = lv1a_q;
    assign out_trig_bits = trig_bits_q;
    assign out_event_num = event_num_q;
    assign out_busy      = (state_q == DEAD);
    assign acc_cnt       = acc_cnt_q;
    assign lost_cnt      = lost_cnt_q;

endmodule

// File: tb/tb_lv1a_prescale_merge.sv
// Directed, table-driven bench for lv1a_prescale_merge.
module tb_lv1a_prescale_merge;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_lv1a;
    logic        in_live;
    logic [63:0] user_prescale;
    logic [7:0]  user_deadtime;
    logic        out_lv1a;
    logic [3:0]  out_trig_bits;
    logic [15:0] out_event_num;
    logic        out_busy;
    logic [63:0] acc_cnt;
    logic [15:0] lost_cnt;

    int total = 0;
    int bad   = 0;

    lv1a_prescale_merge dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_lv1a       (in_lv1a),
        .in_live       (in_live),
        .user_prescale (user_prescale),
        .user_deadtime (user_deadtime),
        .out_lv1a      (out_lv1a),
        .out_trig_bits (out_trig_bits),
        .out_event_num (out_event_num),
        .out_busy      (out_busy),
        .acc_cnt       (acc_cnt),
        .lost_cnt      (lost_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  in_bits;
        logic        exp_lv1a;
        logic [3:0]  exp_bits;
        logic [15:0] exp_ev;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] acc_of(input int i);
        return acc_cnt[i*16 +: 16];
    endfunction

    task automatic live_cycle();
        in_live = 1'b0;
        step();
        in_live = 1'b1;
        step();
    endtask

    initial begin
        tbl[0] = '{4'b0001, 1'b1, 4'b0001, 16'd1};
        tbl[1] = '{4'b0000, 1'b0, 4'b0001, 16'd1};
        tbl[2] = '{4'b1011, 1'b1, 4'b1011, 16'd2};
        tbl[3] = '{4'b0100, 1'b1, 4'b0100, 16'd3};
        tbl[4] = '{4'b0000, 1'b0, 4'b0100, 16'd3};
        tbl[5] = '{4'b1111, 1'b1, 4'b1111, 16'd4};

        rst_n         = 1'b0;
        in_lv1a       = 4'b0000;
        in_live       = 1'b0;
        user_prescale = {16'd1, 16'd1, 16'd1, 16'd1};
        user_deadtime = 8'd0;
        #12;
        check("rst_lv1a",  32'(out_lv1a), 32'd0);
        check("rst_bits",  32'(out_trig_bits), 32'd0);
        check("rst_ev",    32'(out_event_num), 32'd0);
        check("rst_busy",  32'(out_busy), 32'd0);
        check("rst_acc",   32'(acc_cnt[31:0] | acc_cnt[63:32]), 32'd0);
        check("rst_lost",  32'(lost_cnt), 32'd0);
        rst_n = 1'b1;
        step();
        in_live = 1'b1;
        step();

        // table: prescale 1, deadtime 0, one issue per nonzero input
        for (int k = 0; k < 6; k++) begin
            in_lv1a = tbl[k].in_bits;
            step();
            in_lv1a = 4'b0000;
            check($sformatf("tbl%0d_lv1a", k), 32'(out_lv1a), 32'(tbl[k].exp_lv1a));
            check($sformatf("tbl%0d_bits", k), 32'(out_trig_bits), 32'(tbl[k].exp_bits));
            check($sformatf("tbl%0d_ev", k),   32'(out_event_num), 32'(tbl[k].exp_ev));
            check($sformatf("tbl%0d_busy", k), 32'(out_busy), 32'd0);
        end
        step();
        check("tbl_pulse_width", 32'(out_lv1a), 32'd0);
        check("tbl_acc0", 32'(acc_of(0)), 32'd3);
        check("tbl_acc1", 32'(acc_of(1)), 32'd2);
        check("tbl_acc2", 32'(acc_of(2)), 32'd2);
        check("tbl_acc3", 32'(acc_of(3)), 32'd2);
        check("tbl_lost", 32'(lost_cnt), 32'd0);

        // prescale 3 on type 1, disabled type 2
        user_prescale = {16'd1, 16'd0, 16'd3, 16'd1};
        live_cycle();
        check("ps_clr_ev",   32'(out_event_num), 32'd0);
        check("ps_clr_acc0", 32'(acc_of(0)), 32'd0);
        for (int k = 0; k < 9; k++) begin
            in_lv1a = 4'b0010;
            step();
            in_lv1a = 4'b0000;
            check($sformatf("ps3_pulse%0d", k), 32'(out_lv1a), 32'((k % 3) == 2));
            repeat (9) step();
        end
        check("ps3_acc1", 32'(acc_of(1)), 32'd3);
        check("ps3_ev",   32'(out_event_num), 32'd3);
        for (int k = 0; k < 3; k++) begin
            in_lv1a = 4'b0100;
            step();
            in_lv1a = 4'b0000;
            check($sformatf("ps0_pulse%0d", k), 32'(out_lv1a), 32'd0);
        end
        check("ps0_acc2", 32'(acc_of(2)), 32'd0);
        check("ps0_ev",   32'(out_event_num), 32'd3);

        // deadtime 5, type 0 every cycle for 20 cycles
        user_prescale = {16'd1, 16'd1, 16'd1, 16'd1};
        user_deadtime = 8'd5;
        live_cycle();
        for (int k = 0; k < 26; k++) begin
            in_lv1a = (k < 20) ? 4'b0001 : 4'b0000;
            step();
            check($sformatf("dt_lv1a_s%0d", k), 32'(out_lv1a), 32'((k < 20) && (k % 6 == 0)));
            check($sformatf("dt_busy_s%0d", k), 32'(out_busy), 32'((k <= 22) && (k % 6 < 5)));
        end
        in_lv1a = 4'b0000;
        check("dt_ev",   32'(out_event_num), 32'd4);
        check("dt_acc0", 32'(acc_of(0)), 32'd4);
        check("dt_lost", 32'(lost_cnt), 32'd16);

        // live off: counters held, no issues
        in_live = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in_lv1a = 4'b1111;
            step();
            check($sformatf("off_lv1a%0d", k), 32'(out_lv1a), 32'd0);
        end
        check("off_acc0", 32'(acc_of(0)), 32'd4);
        check("off_ev",   32'(out_event_num), 32'd4);
        check("off_lost", 32'(lost_cnt), 32'd16);
        in_live = 1'b1;
        in_lv1a = 4'b0001;
        step();
        in_lv1a = 4'b0000;
        check("rise_lv1a", 32'(out_lv1a), 32'd1);
        check("rise_acc0", 32'(acc_of(0)), 32'd1);
        check("rise_ev",   32'(out_event_num), 32'd1);
        check("rise_lost", 32'(lost_cnt), 32'd0);
        repeat (6) step();

        // reset in the middle of a long deadtime
        user_deadtime = 8'd200;
        in_lv1a = 4'b1000;
        step();
        in_lv1a = 4'b0000;
        check("long_lv1a", 32'(out_lv1a), 32'd1);
        check("long_busy", 32'(out_busy), 32'd1);
        repeat (49) step();
        check("long_busy_c50", 32'(out_busy), 32'd1);
        rst_n = 1'b0;
        #2;
        check("arst_busy", 32'(out_busy), 32'd0);
        check("arst_bits", 32'(out_trig_bits), 32'd0);
        check("arst_ev",   32'(out_event_num), 32'd0);
        check("arst_acc",  32'(acc_cnt[31:0] | acc_cnt[63:32]), 32'd0);
        step();
        rst_n = 1'b1;
        user_deadtime = 8'd0;
        step();
        in_lv1a = 4'b0001;
        step();
        in_lv1a = 4'b0000;
        check("post_lv1a", 32'(out_lv1a), 32'd1);
        check("post_ev",   32'(out_event_num), 32'd1);
        check("post_acc0", 32'(acc_of(0)), 32'd1);
        check("post_busy", 32'(out_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
